button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input conditioning stage directly upstream of the serial-unit control FSM. Takes raw active-low, asynchronous, bouncing pushbutton inputs (LoadA, LoadB, Execute keys) and produces clean, synchronous, active-high levels plus single-cycle press/release pulses. The control FSM consumes the levels directly: Execute must stay asserted while held, so it can gate the DONE→STOP return. Each channel is independent; all share one clock and reset.

## Interface

- N_BTN, default 3: number of button channels (bit 0 LoadA, bit 1 LoadB, bit 2 Execute).
- DB_CYCLES, default 50000: consecutive stable samples required to accept a change (1 ms at 50 MHz); must be ≥2.
- SYNC_STAGES, default 2: synchronizer flop depth; must be ≥2.

- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset: sampled on posedge Clk, 0 = reset.
- key_n  in  N_BTN  raw buttons, active-low (0 = pressed), asynchronous to Clk.
- level  out  N_BTN  debounced state, active-high (1 = pressed).
- press  out  N_BTN  one-cycle pulse on accepted press.
- release  out  N_BTN  one-cycle pulse on accepted release.

## Operation

- Per channel: SYNC_STAGES-flop synchronizer on key_n, inverted to active-high sample s.
- Counter width: $clog2(DB_CYCLES) bits; saturates; never wraps.
- Per-channel FSM states:
  - IDLE: level=0. s=1 → PRESS_WAIT, counter cleared to 0.
  - PRESS_WAIT: level=0. s=0 → IDLE (bounce rejected, no pulse). s=1 → counter+1; when counter reaches DB_CYCLES-1 with s=1 → PRESSED, press=1 for that one cycle.
  - PRESSED: level=1. s=0 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: level=1. s=1 → PRESSED (no pulse). s=0 → counter+1; at DB_CYCLES-1 → IDLE, release=1 for one cycle.
- Outputs are registered: level, press and release change only on Clk edges; no combinational path from key_n.
- press and release never both high on one channel in the same cycle; press pulses never on consecutive cycles.
- Channels simultaneous and independent: pressing all three keys on the same cycle yields three press pulses on the same cycle.

## Timing

- Reset (Reset=0 on an edge): all FSMs → IDLE, counters → 0, level=0, press=0, release=0, synchronizer flops → 1 (released). Applies mid-debounce and mid-press; pending transitions are discarded, no pulse emitted.
- Button held through reset: after Reset returns to 1, it is treated as a fresh press: press pulse after the full latency below.
- Press latency: a clean press held from cycle t gives level=1 and press=1 first visible at the output at cycle t + SYNC_STAGES + DB_CYCLES. Release latency is identical.
- Any single-cycle glitch in s during a WAIT state restarts the full DB_CYCLES window.
- Glitch shorter than DB_CYCLES in IDLE or PRESSED: outputs unchanged.

## Structure

- Shared package: typedef enum logic [1:0] for the per-channel state {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}; default DB_CYCLES and SYNC_STAGES constants, for reuse by other labs' input stages.
- Sub-module btn_debounce: one channel (synchronizer, counter, FSM, registered outputs); the top instantiates N_BTN copies in a generate loop.

## Test plan

Bench uses DB_CYCLES=4, SYNC_STAGES=2.
- Reset: Reset=0 for 2 cycles with key_n=3'b000 → level=000, press=000, release=000; after Reset=1, press=111 exactly 6 cycles later, then level=111.
- Clean press of Execute (key_n[2] 1→0 held) → level[2]=1 and press[2]=1 six cycles after the edge; press[2] low the following cycle; level[0:1] stay 0.
- Bounce: key_n[0] low 3 cycles, high 1, low 10 → single press[0] pulse, 6 cycles after the final low edge; no release pulse.
- Release of held LoadB → release[1]=1 six cycles after key_n[1] goes high, level[1]=0 from the same cycle.
- Reset mid-debounce: key_n[1] low, Reset=0 at cycle 3 of the window → no press pulse; after Reset=1, press only after a full 6-cycle window.
- Glitch in PRESSED: key_n[2] high for 2 cycles while pressed → level[2] stays 1, release[2] never asserts.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for pushbutton input conditioning stages.
package button_conditioner_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 1 ms of stable input at a 50 MHz system clock.
  localparam int DB_CYCLES_DEFAULT   = 50000;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Counter width for a debounce window; at least one bit so the
  // smallest legal window (2) still has a counter.
  function automatic int cnt_width(input int db_cycles);
    int w;
    w = $clog2(db_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// One pushbutton channel: synchronizer, stability counter, debounce FSM
// and registered level/press/release outputs.
//
// state        | meaning
// IDLE         | released, waiting for a pressed sample
// PRESS_WAIT   | counting consecutive pressed samples
// PRESSED      | pressed, waiting for a released sample
// RELEASE_WAIT | counting consecutive released samples
module btn_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int             CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;
  btn_state_t             state;

  // Synchronizer chain; resets to the released level so a held key
  // after reset is seen as a fresh press.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
    end
  end

  assign s = ~sync[SYNC_STAGES-1];

  // Saturating increment so the counter can never wrap.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != CNT_LAST) begin
      cnt_inc = cnt + 1'b1;
    end
  end

  // Debounce FSM; the state entry sample counts as the first stable
  // sample, so the window closes when the count reaches DB_CYCLES-1.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state <= PRESSED;
              level <= 1'b1;
              press <= 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state         <= IDLE;
              level         <= 1'b0;
              release_pulse <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw active-low bouncing pushbuttons into clean synchronous
// active-high levels plus one-cycle press/release pulses. The release
// pulse output is named release_pulse because "release" is reserved.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN       = 3,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] key_n,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse
);

  // Channels are fully independent; one debouncer per key.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES   (DB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_btn (
      .Clk           (Clk),
      .Reset         (Reset),
      .key_n         (key_n[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a sample-history model checked every
// cycle, plus hand-computed checkpoints at the expected latencies.
module tb_button_conditioner;

  localparam int N    = 3;
  localparam int DB   = 4;
  localparam int SS   = 2;
  localparam int MAXC = 4096;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [N-1:0] key_n;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;

  always #5 Clk = ~Clk;

  button_conditioner #(
    .N_BTN       (N),
    .DB_CYCLES   (DB),
    .SYNC_STAGES (SS)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .key_n         (key_n),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse)
  );

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [N-1:0] r_hist [MAXC];
  logic [N-1:0] s_hist [MAXC];
  bit           rst_hist [MAXC];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel = '0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d actual %b required %b", name, cyc, act, exp);
    end
  endtask

  // Model: the key as seen SS edges later (released while the chain
  // refills after reset); a level flips once the last DB seen samples
  // all disagree with it.
  always @(posedge Clk) begin
    int  e;
    bit  all;
    cyc++;
    e = cyc;
    if (e < MAXC) begin
      r_hist[e]   = ~key_n;
      rst_hist[e] = ~Reset;
      m_press     = '0;
      m_rel       = '0;
      if (rst_hist[e]) begin
        s_hist[e] = '0;
        m_level   = '0;
      end else begin
        if (e < SS || rst_hist[e-1] || rst_hist[e-2]) s_hist[e] = '0;
        else s_hist[e] = r_hist[e-SS];
        for (int b = 0; b < N; b++) begin
          all = 1'b1;
          for (int k = 0; k < DB; k++) begin
            if (e - k < 0) all = 1'b0;
            else if (s_hist[e-k][b] == m_level[b]) all = 1'b0;
          end
          if (all) begin
            m_level[b] = ~m_level[b];
            if (m_level[b]) m_press[b] = 1'b1;
            else m_rel[b] = 1'b1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (cyc >= 1) begin
      check("model_level", level, m_level);
      check("model_press", press, m_press);
      check("model_release", release_pulse, m_rel);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    key_n = 3'b000;
    step(2);
    check("rst_level", level, 3'b000);
    check("rst_press", press, 3'b000);
    check("rst_release", release_pulse, 3'b000);
    Reset = 1'b1;
    step(5);
    check("held_rst_press_early", press, 3'b000);
    step(1);
    check("held_rst_press", press, 3'b111);
    check("held_rst_level", level, 3'b111);
    step(1);
    check("held_rst_press_once", press, 3'b000);
    check("held_rst_level_hold", level, 3'b111);

    key_n = 3'b111;
    step(5);
    check("all_rel_early", release_pulse, 3'b000);
    step(1);
    check("all_rel", release_pulse, 3'b111);
    check("all_rel_level", level, 3'b000);
    step(2);

    key_n = 3'b011;
    step(6);
    check("exec_press", press, 3'b100);
    check("exec_level", level, 3'b100);
    step(1);
    check("exec_press_once", press, 3'b000);
    key_n = 3'b111;
    step(8);

    key_n = 3'b110;
    step(3);
    key_n = 3'b111;
    step(1);
    key_n = 3'b110;
    step(6);
    check("bounce_press", press, 3'b001);
    check("bounce_level", level, 3'b001);
    step(1);
    check("bounce_press_once", press, 3'b000);
    step(3);
    check("bounce_no_release", release_pulse, 3'b000);
    check("bounce_level_hold", level, 3'b001);
    key_n = 3'b111;
    step(8);

    key_n = 3'b101;
    step(8);
    key_n = 3'b111;
    step(5);
    check("loadb_rel_early", release_pulse, 3'b000);
    check("loadb_level_early", level, 3'b010);
    step(1);
    check("loadb_rel", release_pulse, 3'b010);
    check("loadb_rel_level", level, 3'b000);
    step(2);

    key_n = 3'b101;
    step(3);
    Reset = 1'b0;
    step(2);
    check("mid_rst_level", level, 3'b000);
    Reset = 1'b1;
    step(5);
    check("mid_rst_press_early", press, 3'b000);
    step(1);
    check("mid_rst_press", press, 3'b010);
    check("mid_rst_level_after", level, 3'b010);
    key_n = 3'b111;
    step(8);

    key_n = 3'b011;
    step(8);
    key_n = 3'b111;
    step(2);
    key_n = 3'b011;
    step(10);
    check("glitch_level", level, 3'b100);
    check("glitch_no_release", release_pulse, 3'b000);

    key_n = 3'b111;
    step(2);
    key_n = 3'b011;
    step(1);
    key_n = 3'b111;
    step(6);
    check("rw_glitch_release", release_pulse, 3'b100);
    check("rw_glitch_level", level, 3'b000);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
